// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter and its priority picker.
package mem_bus_arbiter_pkg;

  localparam int NUM_REQ   = 3;
  localparam int REQ_FETCH = 0;
  localparam int REQ_MEM0  = 1;
  localparam int REQ_MEM1  = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
  } arb_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_arb_priority.sv
// Combinational winner selection: lane 0, lane 1, then fetch, except that a
// starved fetch jumps the queue once the starvation counter saturates.
module arb_priority
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic               flash,
  input  logic [CNT_W-1:0]   starve_cnt,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  logic [NUM_REQ-1:0] elig;

  always_comb begin
    elig            = req & ~mask;
    elig[REQ_FETCH] = elig[REQ_FETCH] & ~flash;
    grant           = '0;
    if (elig[REQ_FETCH] && (starve_cnt == CNT_W'(STARVE_LIMIT))) begin
      grant[REQ_FETCH] = 1'b1;
    end else if (elig[REQ_MEM0]) begin
      grant[REQ_MEM0] = 1'b1;
    end else if (elig[REQ_MEM1]) begin
      grant[REQ_MEM1] = 1'b1;
    end else if (elig[REQ_FETCH]) begin
      grant[REQ_FETCH] = 1'b1;
    end
    valid = |elig;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Three-requester memory bus arbiter (IDLE -> BUS -> RESP sequencer).
// Optional bus timeout is enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flash,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0][31:0]  req_addr,
  input  logic [NUM_REQ-1:0][31:0]  req_wdata,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0][3:0]   req_be,
  output logic [NUM_REQ-1:0]        done,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      bus_req,
  output logic [31:0]               bus_addr,
  output logic [31:0]               bus_wdata,
  output logic                      bus_we,
  output logic [3:0]                bus_be,
  input  logic                      bus_ack,
  input  logic [31:0]               bus_rdata,
  output logic                      stall_from_arbiter
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] win_q, win_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  arb_req_t           cmd_q, cmd_d;
  logic               bus_req_q, bus_req_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               drop_q, drop_d;
  logic [SC_W-1:0]    starve_cnt_q, starve_cnt_d;
`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               err_q, err_d;
`endif

  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  arb_req_t           req_vec [NUM_REQ];
  arb_req_t           sel;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_vec[gi] = '{addr: req_addr[gi], wdata: req_wdata[gi],
                           we: req_we[gi], be: req_be[gi]};
  end

  arb_priority #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(SC_W)) u_prio (
    .req        (req),
    .mask       (mask_q),
    .flash      (flash),
    .starve_cnt (starve_cnt_q),
    .grant      (grant),
    .valid      (grant_valid)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel = req_vec[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    cmd_d        = cmd_q;
    bus_req_d    = bus_req_q;
    done_d       = '0;
    mask_d       = done_q;
    rdata_d      = rdata_q;
    drop_d       = drop_q;
    starve_cnt_d = starve_cnt_q;
`ifdef ARB_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    err_d        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (grant_valid) begin
          state_d   = BUS;
          win_d     = grant;
          cmd_d     = sel;
          bus_req_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
        end
      end
      BUS: begin
        // A flushed fetch still finishes on the bus; only its done is hidden.
        drop_d = drop_q | (flash & win_q[REQ_FETCH]);
        if (bus_ack) begin
          state_d           = RESP;
          bus_req_d         = 1'b0;
          rdata_d           = bus_rdata;
          done_d            = win_q;
          done_d[REQ_FETCH] = win_q[REQ_FETCH] & ~drop_d;
`ifdef ARB_TIMEOUT_EN
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d           = RESP;
          bus_req_d         = 1'b0;
          rdata_d           = '0;
          err_d             = 1'b1;
          done_d            = win_q;
          done_d[REQ_FETCH] = win_q[REQ_FETCH] & ~drop_d;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (!req[REQ_FETCH]) begin
      starve_cnt_d = '0;
    end else if (state_q == IDLE && grant_valid) begin
      if (grant[REQ_FETCH]) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != SC_W'(STARVE_LIMIT)) begin
        starve_cnt_d = starve_cnt_q + SC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      win_q        <= '0;
      done_q       <= '0;
      mask_q       <= '0;
      cmd_q        <= '0;
      bus_req_q    <= 1'b0;
      rdata_q      <= '0;
      drop_q       <= 1'b0;
      starve_cnt_q <= '0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      done_q       <= done_d;
      mask_q       <= mask_d;
      cmd_q        <= cmd_d;
      bus_req_q    <= bus_req_d;
      rdata_q      <= rdata_d;
      drop_q       <= drop_d;
      starve_cnt_q <= starve_cnt_d;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign done      = done_q;
  assign rsp_rdata = rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_addr  = cmd_q.addr;
  assign bus_wdata = cmd_q.wdata;
  assign bus_we    = cmd_q.we;
  assign bus_be    = cmd_q.be;
`ifdef ARB_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif
  assign stall_from_arbiter = (req[REQ_MEM0] & ~done_q[REQ_MEM0]) |
                              (req[REQ_MEM1] & ~done_q[REQ_MEM1]);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed and randomized transactions
// against a transaction-level priority/starvation model and a simple bus slave.
module tb_mem_bus_arbiter;

  localparam int STARVE = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flash = 1'b0;
  logic [2:0]       req = '0;
  logic [2:0][31:0] req_addr = '0;
  logic [2:0][31:0] req_wdata = '0;
  logic [2:0]       req_we = '0;
  logic [2:0][3:0]  req_be = '0;
  logic [2:0]       done;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             bus_req;
  logic [31:0]      bus_addr;
  logic [31:0]      bus_wdata;
  logic             bus_we;
  logic [3:0]       bus_be;
  logic             bus_ack = 1'b0;
  logic [31:0]      bus_rdata = '0;
  logic             stall;

  int          checks = 0;
  int          failures = 0;
  int          wait_states = 0;
  bit          ack_en = 1'b1;
  int          bcnt = 0;
  int          ack_cnt = 0;
  logic [31:0] last_rdata = '0;
  bit          force_en = 1'b0;
  logic [31:0] force_val = '0;
  int          sc_m = 0;
  int          last_m = -1;

  mem_bus_arbiter #(
    .STARVE_LIMIT(STARVE)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst(rst), .flash(flash), .req(req),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_be(req_be),
    .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall_from_arbiter(stall)
  );

  always #5 clk = ~clk;

  // Bus slave: acks after wait_states cycles of bus_req, with random read data.
  initial begin
    forever begin
      @(negedge clk);
      if (rst || !bus_req) begin
        bus_ack = 1'b0;
        bcnt    = 0;
      end else begin
        if (ack_en && bcnt == wait_states) begin
          bus_ack    = 1'b1;
          bus_rdata  = force_en ? force_val : $urandom;
          last_rdata = bus_rdata;
          ack_cnt++;
        end else begin
          bus_ack = 1'b0;
        end
        bcnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spec-level pick: last-served requester sits out, saturated starvation favours fetch.
  function automatic int model_pick(input logic [2:0] pend, input int last, input int sc);
    logic [2:0] e;
    e = pend;
    if (last >= 0) e[last] = 1'b0;
    if (e[0] && sc >= STARVE) return 0;
    for (int i = 1; i <= 2; i++) if (e[i]) return i;
    if (e[0]) return 0;
    return -1;
  endfunction

  task automatic wait_done(input int ei, output logic [2:0] d, output int n, output int busc);
    d = '0; n = 0; busc = 0;
    while (n < 60 && d == 0) begin
      tick();
      n++;
      if (bus_req) begin
        busc++;
        if (ei >= 0) begin
          chk("bus_addr", bus_addr, req_addr[ei]);
          chk("bus_wdata", bus_wdata, req_wdata[ei]);
          chk("bus_we", 32'(bus_we), 32'(req_we[ei]));
          chk("bus_be", 32'(bus_be), 32'(req_be[ei]));
        end
      end
      if (done != 0) d = done;
    end
    if (d == 0) begin
      checks++;
      failures++;
      $error("FAIL done_wait observed=no_pulse expected=pulse_within_60_cycles");
    end
  endtask

  task automatic do_txn(input int r, input logic [31:0] a, input logic [31:0] wd,
                        input logic we, input logic [3:0] be, input int waits);
    logic [2:0] d;
    int n, busc;
    wait_states  = waits;
    req_addr[r]  = a;
    req_wdata[r] = wd;
    req_we[r]    = we;
    req_be[r]    = be;
    req[r]       = 1'b1;
    wait_done(r, d, n, busc);
    chk("done_onehot", 32'(d), 32'(1) << r);
    chk("latency", 32'(n), 32'(waits + 2));
    chk("bus_cycles", 32'(busc), 32'(waits + 1));
    chk("rsp_rdata", rsp_rdata, last_rdata);
    chk("rsp_err", 32'(rsp_err), 32'(0));
    chk("stall_at_done", 32'(stall), 32'(0));
    $display("TXN req=%0d addr=%h we=%0b be=%h waits=%0d done=%b lat=%0d rdata=%h",
             r, a, we, be, waits, d, n, rsp_rdata);
    tick();
    req[r] = 1'b0;
    tick();
  endtask

  task automatic contend(input int ngr);
    logic [2:0] d;
    int n, busc, w;
    for (int k = 0; k < ngr; k++) begin
      w = model_pick(req, last_m, sc_m);
      wait_states = int'($urandom_range(0, 2));
      wait_done(w, d, n, busc);
      chk("grant_order", 32'(d), 32'(1) << w);
      chk("stall_contend", 32'(stall), 32'(1));
      if (w == 0) sc_m = 0;
      else if (req[0]) sc_m = (sc_m + 1 > STARVE) ? STARVE : sc_m + 1;
      last_m = w;
      $display("GRANT k=%0d expected=%0d done=%b starve_model=%0d", k, w, d, sc_m);
    end
  endtask

  initial begin
    logic [2:0] d;
    int n, busc, a0, seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_bus_req", 32'(bus_req), 32'(0));
    chk("rst_bus_addr", bus_addr, 32'(0));
    chk("rst_bus_wdata", bus_wdata, 32'(0));
    chk("rst_bus_be_we", 32'({bus_be, bus_we}), 32'(0));
    chk("rst_rsp_rdata", rsp_rdata, 32'(0));
    chk("rst_stall", 32'(stall), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();

    force_en = 1'b1;
    force_val = 32'h2408_0001;
    do_txn(0, 32'h0040_0000, 32'h0, 1'b0, 4'hf, 0);
    chk("fetch_rdata_const", rsp_rdata, 32'h2408_0001);
    force_en = 1'b0;

    do_txn(2, 32'h1000_0004, 32'hDEAD_BEEF, 1'b1, 4'b0011, 1);

    for (int i = 0; i < 16; i++) begin
      do_txn(int'($urandom_range(0, 2)), $urandom, $urandom, 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    // Flush during BUS: transaction completes on the bus, done[0] never shows.
    a0 = ack_cnt;
    wait_states = 3;
    req_addr[0] = $urandom;
    req[0] = 1'b1;
    tick();
    chk("flush_bus_started", 32'(bus_req), 32'(1));
    tick();
    flash = 1'b1;
    req[0] = 1'b0;
    tick();
    flash = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done != 0) seen++;
    end
    chk("flush_no_done", 32'(seen), 32'(0));
    chk("flush_ack_count", 32'(ack_cnt - a0), 32'(1));
    chk("flush_bus_idle", 32'(bus_req), 32'(0));
    $display("TXN flush_in_bus acks=%0d done_pulses=%0d", ack_cnt - a0, seen);

    // Flush in IDLE with only fetch requesting: no grant that cycle.
    wait_states = 0;
    req[0] = 1'b1;
    flash = 1'b1;
    tick();
    chk("flush_idle_no_grant", 32'(bus_req), 32'(0));
    flash = 1'b0;
    wait_done(0, d, n, busc);
    chk("flush_idle_then_done", 32'(d), 32'b001);
    chk("flush_idle_latency", 32'(n), 32'(2));
    $display("TXN flush_in_idle then fetch done=%b lat=%0d", d, n);
    tick();
    req[0] = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) begin
      req_addr[i] = $urandom;
      req_wdata[i] = $urandom;
      req_we[i] = 1'($urandom_range(0, 1));
      req_be[i] = 4'($urandom_range(0, 15));
    end
    req = 3'b111;
    sc_m = 0;
    last_m = -1;
    contend(10);
    tick();
    req = 3'b000;
    tick();
    chk("stall_released", 32'(stall), 32'(0));

`ifdef ARB_TIMEOUT_EN
    ack_en = 1'b0;
    req_addr[1] = $urandom;
    req[1] = 1'b1;
    wait_done(1, d, n, busc);
    chk("to_done", 32'(d), 32'b010);
    chk("to_bus_cycles", 32'(busc), 32'(8));
    chk("to_rsp_err", 32'(rsp_err), 32'(1));
    chk("to_rsp_rdata", rsp_rdata, 32'(0));
    $display("TXN timeout done=%b bus_cycles=%0d err=%0b", d, busc, rsp_err);
    ack_en = 1'b1;
    tick();
    req[1] = 1'b0;
    tick();
`endif

    // Build up starvation, then reset asynchronously mid-BUS.
    req = 3'b111;
    sc_m = 0;
    last_m = -1;
    contend(3);
    wait_states = 6;
    tick();
    tick();
    tick();
    chk("pre_reset_bus_req", 32'(bus_req), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_bus_req", 32'(bus_req), 32'(0));
    chk("async_rst_done", 32'(done), 32'(0));
    $display("TXN async_reset bus_req=%0b done=%b", bus_req, done);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sc_m = 0;
    last_m = -1;
    contend(5);
    tick();
    req = 3'b000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
